conf_mul_scheduler: RTL and testbench

//   Shares one conf_int_mul__noFF__arch_agnos__w_wrapper instance between two requesters.

---
 rtl/conf_mul_scheduler_if.sv | 41 ++++
 rtl/conf_mul_scheduler.sv | 139 +++++++++++++
 tb/tb_conf_mul_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conf_mul_scheduler_if.sv
// Bundle between the IDCT pass controllers, the multiplier scheduler and the
// multiplier wrapper; slave is the scheduler's view, master is the surrounding logic.
interface conf_mul_scheduler_if #(
  parameter int DPW = 24
);
  logic [1:0]     req_valid;
  logic [DPW-1:0] req_a0;
  logic [DPW-1:0] req_b0;
  logic [DPW-1:0] req_a1;
  logic [DPW-1:0] req_b1;
  logic [1:0]     req_apx;
  logic           apx_en;
  logic [1:0]     req_ready;
  logic           resp_valid;
  logic           resp_ready;
  logic [31:0]    resp_p;
  logic           resp_id;
  logic [15:0]    op_count;
  logic [DPW-1:0] mul_a;
  logic [DPW-1:0] mul_b;
  logic [2:0]     mul_state;
  logic [8:0]     mul_count0;
  logic           mul_rapx;
  logic           mul_racc;
  logic           mul_rstP;
  logic [31:0]    mul_p;

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, req_apx, apx_en,
    input  resp_ready, mul_p,
    output req_ready, resp_valid, resp_p, resp_id, op_count,
    output mul_a, mul_b, mul_state, mul_count0, mul_rapx, mul_racc, mul_rstP
  );

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, req_apx, apx_en,
    output resp_ready, mul_p,
    input  req_ready, resp_valid, resp_p, resp_id, op_count,
    input  mul_a, mul_b, mul_state, mul_count0, mul_rapx, mul_racc, mul_rstP
  );
endinterface

// File: rtl/conf_mul_scheduler.sv
// Round-robin sharing of one multiplier wrapper between the row and column
// IDCT passes; sequences the wrapper's state/count0 load protocol per operation.
module conf_mul_scheduler #(
  parameter int OP_BITWIDTH        = 16,
  parameter int DATA_PATH_BITWIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rstN,
  conf_mul_scheduler_if.slave  bus_io
);
  localparam int DPW = DATA_PATH_BITWIDTH;
  // Wrapper load count scales with the operator width (63 for 16-bit operators).
  localparam logic [8:0] LOAD_COUNT = 9'(4 * OP_BITWIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_HOLD, S_DRAIN, S_CAPT, S_RESP
  } state_t;

  state_t         state_q, state_d;
  logic           racc_q;
  logic           last_grant_q, last_grant_d;
  logic [DPW-1:0] a_q, a_d, b_q, b_d;
  logic           id_q, id_d;
  logic           apx_q, apx_d;
  logic [31:0]    resp_p_q, resp_p_d;
  logic           resp_id_q, resp_id_d;
  logic [15:0]    op_count_q, op_count_d;
  logic           grant;
  logic [1:0]     req_ready;
  logic           resp_valid;
  logic [2:0]     mul_state;
  logic [8:0]     mul_count0;
  logic           mul_rapx;

  // On a tie the requester that did not win last time gets the slot.
  assign grant = (&bus_io.req_valid) ? ~last_grant_q : bus_io.req_valid[1];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    apx_d        = apx_q;
    resp_p_d     = resp_p_q;
    resp_id_d    = resp_id_q;
    op_count_d   = op_count_q;
    req_ready    = 2'b00;
    resp_valid   = 1'b0;
    mul_state    = 3'b000;
    mul_count0   = 9'd0;
    mul_rapx     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!racc_q && (|bus_io.req_valid)) begin
          req_ready    = grant ? 2'b10 : 2'b01;
          a_d          = grant ? bus_io.req_a1 : bus_io.req_a0;
          b_d          = grant ? bus_io.req_b1 : bus_io.req_b0;
          id_d         = grant;
          apx_d        = bus_io.req_apx[grant] & bus_io.apx_en;
          last_grant_d = grant;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mul_state  = 3'b001;
        mul_count0 = LOAD_COUNT;
        mul_rapx   = apx_q;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        mul_state  = 3'b010;
        mul_count0 = LOAD_COUNT;
        mul_rapx   = apx_q;
        state_d    = S_DRAIN;
      end
      S_DRAIN: begin
        mul_state  = 3'b010;
        mul_count0 = LOAD_COUNT;
        mul_rapx   = apx_q;
        state_d    = S_CAPT;
      end
      S_CAPT: begin
        resp_p_d  = bus_io.mul_p;
        resp_id_d = id_q;
        state_d   = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (bus_io.resp_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // racc_q doubles as the wrapper's racc/rstP and blocks arbitration for the
  // first cycle after reset release.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= S_IDLE;
      racc_q       <= 1'b1;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      apx_q        <= 1'b0;
      resp_p_q     <= 32'd0;
      resp_id_q    <= 1'b0;
      op_count_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      racc_q       <= 1'b0;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      apx_q        <= apx_d;
      resp_p_q     <= resp_p_d;
      resp_id_q    <= resp_id_d;
      op_count_q   <= op_count_d;
    end
  end

  assign bus_io.req_ready  = req_ready;
  assign bus_io.resp_valid = resp_valid;
  assign bus_io.resp_p     = resp_p_q;
  assign bus_io.resp_id    = resp_id_q;
  assign bus_io.op_count   = op_count_q;
  assign bus_io.mul_a      = a_q;
  assign bus_io.mul_b      = b_q;
  assign bus_io.mul_state  = mul_state;
  assign bus_io.mul_count0 = mul_count0;
  assign bus_io.mul_rapx   = mul_rapx;
  assign bus_io.mul_racc   = racc_q;
  assign bus_io.mul_rstP   = racc_q;
endmodule

// File: tb/tb_conf_mul_scheduler.sv
// Bench for conf_mul_scheduler: stubbed wrapper product, vector table plus
// hand-written reset, backpressure, mid-op reset and contention sequences.
module tb_conf_mul_scheduler;
  localparam int DPW = 24;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  conf_mul_scheduler_if #(.DPW(DPW)) bus ();

  conf_mul_scheduler #(
    .OP_BITWIDTH       (16),
    .DATA_PATH_BITWIDTH(DPW)
  ) dut (
    .clk   (clk),
    .rstN  (rstN),
    .bus_io(bus)
  );

  // Wrapper stub: product of the presented operands, or a forced value.
  logic        ovr_en;
  logic [31:0] ovr_val;
  logic [47:0] full_prod;
  assign full_prod = 48'(bus.mul_a) * 48'(bus.mul_b);
  assign bus.mul_p = ovr_en ? ovr_val : full_prod[31:0];

  typedef struct packed {
    logic [31:0] p;
    logic        id;
  } exp_t;

  typedef struct packed {
    logic        id;
    logic [23:0] a;
    logic [23:0] b;
    logic        apx;
    logic        en;
    logic        exp_rapx;
    logic [31:0] exp_p;
  } vec_t;

  exp_t  sb[$];
  vec_t  vecs[5];
  int    checks = 0;
  int    failures = 0;
  logic [15:0] exp_count;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic chk_t1);
    @(negedge clk);
    rstN = 1'b0;
    bus.req_valid = 2'b00;
    bus.resp_ready = 1'b0;
    #1;
    chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_resp_p", bus.resp_p, 32'd0);
    chk("rst_resp_id", bus.resp_id, 1'b0);
    chk("rst_op_count", bus.op_count, 16'd0);
    chk("rst_mul_a", bus.mul_a, 24'd0);
    chk("rst_mul_b", bus.mul_b, 24'd0);
    chk("rst_mul_state", bus.mul_state, 3'b000);
    chk("rst_mul_count0", bus.mul_count0, 9'd0);
    chk("rst_mul_rapx", bus.mul_rapx, 1'b0);
    chk("rst_mul_racc", bus.mul_racc, 1'b1);
    chk("rst_mul_rstP", bus.mul_rstP, 1'b1);
    sb.delete();
    exp_count = 16'd0;
    @(negedge clk);
    if (chk_t1) bus.req_valid = 2'b01;
    rstN = 1'b1;
    #1;
    chk("release_racc", bus.mul_racc, 1'b1);
    chk("release_req_ready", bus.req_ready, 2'b00);
    @(negedge clk);
    #1;
    chk("post_release_racc", bus.mul_racc, 1'b0);
    chk("post_release_rstP", bus.mul_rstP, 1'b0);
    if (chk_t1) chk("post_release_req_ready", bus.req_ready, 2'b01);
    bus.req_valid = 2'b00;
    $display("reset done");
  endtask

  task automatic issue(input logic id, input logic [23:0] a, input logic [23:0] b,
                       input logic apx, input logic en, input logic exp_rapx,
                       input logic [31:0] exp_p);
    logic got;
    exp_t e;
    @(negedge clk);
    if (id) begin
      bus.req_a1 = a;
      bus.req_b1 = b;
    end else begin
      bus.req_a0 = a;
      bus.req_b0 = b;
    end
    bus.req_apx   = id ? {apx, 1'b0} : {1'b0, apx};
    bus.apx_en    = en;
    bus.req_valid = id ? 2'b10 : 2'b01;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.req_ready[id]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept", got, 1'b1);
    if (!got) begin
      bus.req_valid = 2'b00;
      return;
    end
    chk("accept_other_ready", bus.req_ready[~id], 1'b0);
    e.p  = exp_p;
    e.id = id;
    sb.push_back(e);
    $display("req id=%0d a=%h b=%h apx=%0d apx_en=%0d", id, a, b, apx, en);
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    chk("t1_state", bus.mul_state, 3'b001);
    chk("t1_count0", bus.mul_count0, 9'd63);
    chk("t1_mul_a", bus.mul_a, a);
    chk("t1_mul_b", bus.mul_b, b);
    chk("t1_rapx", bus.mul_rapx, exp_rapx);
    chk("t1_req_ready", bus.req_ready, 2'b00);
    @(negedge clk);
    #1;
    chk("t2_state", bus.mul_state, 3'b010);
    chk("t2_count0", bus.mul_count0, 9'd63);
    chk("t2_mul_a", bus.mul_a, a);
    chk("t2_rapx", bus.mul_rapx, exp_rapx);
    @(negedge clk);
    #1;
    chk("t3_state", bus.mul_state, 3'b010);
    chk("t3_mul_b", bus.mul_b, b);
    chk("t3_rapx", bus.mul_rapx, exp_rapx);
    @(negedge clk);
    #1;
    chk("t4_state", bus.mul_state, 3'b000);
    chk("t4_rapx", bus.mul_rapx, 1'b0);
    chk("t4_resp_valid", bus.resp_valid, 1'b0);
    @(negedge clk);
    #1;
    chk("t5_resp_valid", bus.resp_valid, 1'b1);
  endtask

  task automatic collect(input int hold);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    chk("resp_p", bus.resp_p, e.p);
    chk("resp_id", bus.resp_id, e.id);
    $display("resp id=%0d p=%h hold=%0d", bus.resp_id, bus.resp_p, hold);
    bus.resp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = 2'b11;
      @(negedge clk);
      #1;
      chk("bp_resp_valid", bus.resp_valid, 1'b1);
      chk("bp_resp_p", bus.resp_p, e.p);
      chk("bp_req_ready", bus.req_ready, 2'b00);
    end
    bus.req_valid  = 2'b00;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    #1;
    chk("after_resp_valid", bus.resp_valid, 1'b0);
    chk("op_count", bus.op_count, exp_count);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    int   nresp;
    int   ngrant;
    logic gid;
    exp_t e;

    vecs[0] = '{id: 1'b0, a: 24'h000003, b: 24'h000005, apx: 1'b0, en: 1'b0, exp_rapx: 1'b0, exp_p: 32'd15};
    vecs[1] = '{id: 1'b1, a: 24'h000100, b: 24'h000100, apx: 1'b1, en: 1'b1, exp_rapx: 1'b1, exp_p: 32'h00010000};
    vecs[2] = '{id: 1'b1, a: 24'hFFFFFF, b: 24'h000002, apx: 1'b1, en: 1'b0, exp_rapx: 1'b0, exp_p: 32'h01FFFFFE};
    vecs[3] = '{id: 1'b0, a: 24'hFFFFFF, b: 24'hFFFFFF, apx: 1'b1, en: 1'b1, exp_rapx: 1'b1, exp_p: 32'hFE000001};
    vecs[4] = '{id: 1'b0, a: 24'h001000, b: 24'h001000, apx: 1'b0, en: 1'b1, exp_rapx: 1'b0, exp_p: 32'h01000000};

    rstN = 1'b0;
    ovr_en = 1'b0;
    ovr_val = 32'd0;
    bus.req_valid = 2'b00;
    bus.req_a0 = '0;
    bus.req_b0 = '0;
    bus.req_a1 = '0;
    bus.req_b1 = '0;
    bus.req_apx = 2'b00;
    bus.apx_en = 1'b0;
    bus.resp_ready = 1'b0;
    exp_count = 16'd0;

    do_reset(1'b1);

    // Single op with a forced wrapper result.
    ovr_en = 1'b1;
    ovr_val = 32'h00001234;
    issue(1'b0, 24'h123456, 24'h000010, 1'b0, 1'b0, 1'b0, 32'h00001234);
    collect(0);
    ovr_en = 1'b0;

    // Table of single-requester ops; vector 2 also sees 10 cycles of backpressure.
    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].apx, vecs[i].en,
            vecs[i].exp_rapx, vecs[i].exp_p);
      collect(i == 2 ? 10 : 0);
    end

    // Reset asserted while the wrapper is in its HOLD cycle.
    @(negedge clk);
    bus.req_a0 = 24'h00ABCD;
    bus.req_b0 = 24'h000003;
    bus.req_apx = 2'b00;
    bus.req_valid = 2'b01;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.req_ready[0]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("midrst_accept", got, 1'b1);
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("midrst_hold_state", bus.mul_state, 3'b010);
    rstN = 1'b0;
    #1;
    chk("midrst_state", bus.mul_state, 3'b000);
    chk("midrst_count0", bus.mul_count0, 9'd0);
    chk("midrst_racc", bus.mul_racc, 1'b1);
    chk("midrst_mul_a", bus.mul_a, 24'd0);
    chk("midrst_resp_valid", bus.resp_valid, 1'b0);
    chk("midrst_op_count", bus.op_count, 16'd0);
    $display("reset asserted mid-op");
    @(negedge clk);
    rstN = 1'b1;
    exp_count = 16'd0;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (bus.resp_valid) got = 1'b1;
    end
    chk("midrst_no_resp", got, 1'b0);
    chk("midrst_count_after", bus.op_count, 16'd0);
    issue(1'b0, 24'h000011, 24'h000002, 1'b0, 1'b0, 1'b0, 32'h00000022);
    collect(0);

    // Both requesters continuously valid: grants must alternate from requester 0.
    do_reset(1'b0);
    @(negedge clk);
    bus.req_a0 = 24'h000007;
    bus.req_b0 = 24'h000009;
    bus.req_a1 = 24'h000020;
    bus.req_b1 = 24'h000030;
    bus.req_apx = 2'b00;
    bus.resp_ready = 1'b1;
    bus.req_valid = 2'b11;
    nresp = 0;
    ngrant = 0;
    for (int c = 0; c < 100 && nresp < 4; c++) begin
      #1;
      if (|(bus.req_ready & bus.req_valid)) begin
        gid = bus.req_ready[1];
        chk("grant_order", gid, ngrant[0]);
        e.id = gid;
        e.p  = gid ? 32'h00000600 : 32'd63;
        sb.push_back(e);
        $display("contention grant=%0d", gid);
        ngrant++;
      end
      if (bus.resp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL contention_scoreboard: got 0 entries expected 1");
        end else begin
          e = sb.pop_front();
          chk("cont_resp_p", bus.resp_p, e.p);
          chk("cont_resp_id", bus.resp_id, e.id);
          $display("contention resp id=%0d p=%h", bus.resp_id, bus.resp_p);
        end
        nresp++;
        if (nresp == 4) bus.req_valid = 2'b00;
      end
      @(negedge clk);
    end
    chk("cont_responses", 48'(nresp), 48'd4);
    #1;
    chk("cont_op_count", bus.op_count, 16'd4);
    chk("cont_resp_valid_after", bus.resp_valid, 1'b0);
    bus.resp_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
